// File: rtl/rhs_convert_sequencer.sv
// SPI master sweeping CONVERT commands over NUM_CHANNELS of an RHS front-end, tagging each result with its channel.
// Optional macro RHS_SEQ_FRAME_CNT_EN adds a free-running 32-bit frame counter output (frame_cnt).
module rhs_convert_sequencer #(
  parameter int NUM_CHANNELS   = 16,
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        SCLK,
  output logic        CS,
  output logic        MOSI,
  input  logic        MISO,
  output logic        busy,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [4:0]  sample_channel,
  output logic        sweep_done
`ifdef RHS_SEQ_FRAME_CNT_EN
  ,
  output logic [31:0] frame_cnt
`endif
);

  localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(CS_HIGH_CYCLES - 1);
  localparam logic [4:0]    LAST_CHAN = 5'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      bit_idx;
  logic [4:0]      cmd_chan;
  logic [1:0]      fill;
  logic [31:0]     tx;
  logic [31:0]     rx;
  logic [4:0]      next_chan;
  logic [4:0]      result_chan;
  logic [31:0]     load_word;

  function automatic logic [31:0] cmd_word(input logic [4:0] ch);
    return {2'b00, 8'h00, 1'b0, ch, 16'h0000};
  endfunction

  // Results lag the command stream by two frames in the front-end pipeline.
  always_comb begin
    next_chan   = (cmd_chan == LAST_CHAN) ? 5'd0 : cmd_chan + 5'd1;
    result_chan = (cmd_chan >= 5'd2) ? cmd_chan - 5'd2 : cmd_chan + 5'(NUM_CHANNELS - 2);
    load_word   = cmd_word((state == GAP) ? next_chan : cmd_chan);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= 5'd0;
      cmd_chan       <= 5'd0;
      fill           <= 2'd0;
      tx             <= 32'd0;
      rx             <= 32'd0;
      SCLK           <= 1'b0;
      CS             <= 1'b1;
      MOSI           <= 1'b0;
      busy           <= 1'b0;
      sample_valid   <= 1'b0;
      sample_data    <= 16'd0;
      sample_channel <= 5'd0;
      sweep_done     <= 1'b0;
`ifdef RHS_SEQ_FRAME_CNT_EN
      frame_cnt      <= 32'd0;
`endif
    end else begin
      sample_valid <= 1'b0;
      sweep_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= LEAD;
            CS    <= 1'b0;
            busy  <= 1'b1;
            tx    <= load_word;
            MOSI  <= load_word[31];
            cnt   <= DIV_LOAD;
          end
        end
        LEAD: begin
          if (cnt == '0) begin
            state   <= SHIFT;
            SCLK    <= 1'b1;
            rx      <= {rx[30:0], MISO};
            bit_idx <= 5'd0;
            cnt     <= DIV_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt <= DIV_LOAD;
            if (SCLK) begin
              SCLK <= 1'b0;
              tx   <= {tx[30:0], 1'b0};
              MOSI <= tx[30];
            end else if (bit_idx == 5'd31) begin
              state <= TRAIL;
            end else begin
              bit_idx <= bit_idx + 5'd1;
              SCLK    <= 1'b1;
              rx      <= {rx[30:0], MISO};
            end
          end
        end
        TRAIL: begin
          if (cnt == '0) begin
            state <= GAP;
            CS    <= 1'b1;
            cnt   <= GAP_LOAD;
            fill  <= (fill == 2'd2) ? 2'd2 : fill + 2'd1;
            if (fill == 2'd2) begin
              sample_valid   <= 1'b1;
              sample_data    <= rx[31:16];
              sample_channel <= result_chan;
              sweep_done     <= (result_chan == LAST_CHAN);
            end
`ifdef RHS_SEQ_FRAME_CNT_EN
            frame_cnt <= frame_cnt + 32'd1;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (enable) begin
            state    <= LEAD;
            CS       <= 1'b0;
            cmd_chan <= next_chan;
            tx       <= load_word;
            MOSI     <= load_word[31];
            cnt      <= DIV_LOAD;
          end else begin
            // A restart must begin at channel 0 and refill the result pipeline.
            state    <= IDLE;
            busy     <= 1'b0;
            fill     <= 2'd0;
            cmd_chan <= 5'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
